hdr_mode_sequencer: RTL and testbench

Parametrised HDR-mode sequencer for the I3C controller. It accepts per-transaction commands (engine index, TOC, mode) through a valid/ready handshake and enables one of `NUM_ENG` HDR sub-engines (CCC, DDR, and future BT/TSP engines). It drives a shared encoded mux select for the TX/RX/regfile/SCL/SDA/CRC muxes and inserts a dummy CCC frame when leaving the CCC engine on a restart. It adds a per-transaction watchdog, and it sits between the I3C engine and the HDR sub-engines.

---
 rtl/hdr_seq_pkg.sv | 21 ++
 rtl/hdr_seq_watchdog.sv | 40 ++++
 rtl/hdr_mode_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_hdr_mode_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_seq_pkg.sv
// hdr_seq_pkg
// Shared definitions for the HDR-mode sequencer: the FSM state encoding,
// the default engine indices, the regfile special addresses and the mode
// code that means "stay in HDR after this transaction".
package hdr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DUMMY = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } hdr_state_t;

    localparam int DDR_ENG_IDX    = 0;
    localparam int CCC_ENG_IDX    = 1;
    localparam int DEF_IDLE_ADDR  = 1000;
    localparam int DEF_DUMMY_ADDR = 450;
    localparam int DEF_HDR_MODE   = 6;

endpackage

// File: rtl/hdr_seq_watchdog.sv
// hdr_seq_watchdog
// Per-transaction cycle counter. It counts while 'enable' is high, restarts
// from zero on 'clear', and flags 'expire' in the cycle whose count (including
// that cycle) reaches 'limit'. A limit of zero never expires.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   clear     : restart the count (state entry)
//   enable    : count this cycle
//   limit     : expiry threshold, 0 = disabled
//   expire    : combinational expiry flag for the current cycle
module hdr_seq_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);

    logic [TMO_W-1:0] count;
    logic [TMO_W:0]   count_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the cycles already spent, so the current cycle is count+1;
    // the extra bit keeps the compare exact when count is all ones.
    assign count_inc = {1'b0, count} + {{TMO_W{1'b0}}, 1'b1};
    assign expire    = enable && (limit != '0) && (count_inc == {1'b0, limit});

endmodule

// File: rtl/hdr_mode_sequencer.sv
// hdr_mode_sequencer
// Sits between the I3C engine and the HDR sub-engines. Accepts commands
// (engine, TOC, mode) over valid/ready, enables one sub-engine at a time,
// drives the shared datapath mux select, inserts a dummy CCC frame when a
// restart leaves the CCC engine, and bounds each transaction with a watchdog.
// Ports:
//   i_sys_clk, i_sys_rst   : clock, asynchronous active-high reset
//   i_hdr_en               : enable from the I3C engine, low forces IDLE
//   i_cmd_valid/o_cmd_ready: command handshake
//   i_cmd_eng/toc/mode     : command fields
//   i_tmo_cycles           : watchdog limit, 0 disables
//   i_eng_done             : per-engine done pulses
//   o_eng_en               : one-hot engine enable
//   o_mux_sel              : shared datapath mux select
//   o_regf_addr_special    : regfile special address (dummy CCC value or idle)
//   o_hdr_done             : HDR exit pulse
//   o_timeout, o_cmd_err   : exit cause pulses, coincident with o_hdr_done
module hdr_mode_sequencer
    import hdr_seq_pkg::*;
#(
    parameter int NUM_ENG    = 2,
    parameter int SEL_W      = $clog2(NUM_ENG),
    parameter int CCC_IDX    = CCC_ENG_IDX,
    parameter int ADDR_W     = 12,
    parameter int IDLE_ADDR  = DEF_IDLE_ADDR,
    parameter int DUMMY_ADDR = DEF_DUMMY_ADDR,
    parameter int HDR_MODE   = DEF_HDR_MODE,
    parameter int TMO_W      = 16
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    input  logic               i_hdr_en,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [SEL_W-1:0]   i_cmd_eng,
    input  logic               i_cmd_toc,
    input  logic [2:0]         i_cmd_mode,
    input  logic [TMO_W-1:0]   i_tmo_cycles,
    input  logic [NUM_ENG-1:0] i_eng_done,
    output logic [NUM_ENG-1:0] o_eng_en,
    output logic [SEL_W-1:0]   o_mux_sel,
    output logic [ADDR_W-1:0]  o_regf_addr_special,
    output logic               o_hdr_done,
    output logic               o_timeout,
    output logic               o_cmd_err
);

    localparam logic [SEL_W-1:0]  CCC_SEL = SEL_W'(CCC_IDX);
    localparam logic [ADDR_W-1:0] IDLE_A  = ADDR_W'(IDLE_ADDR);
    localparam logic [ADDR_W-1:0] DUMMY_A = ADDR_W'(DUMMY_ADDR);
    localparam logic [2:0]        HDR_M   = 3'(HDR_MODE);

    hdr_state_t state, state_nx;

    logic [SEL_W-1:0]   cur_eng, cur_eng_nx, pend_eng, pend_eng_nx;
    logic               cur_toc, cur_toc_nx, pend_toc, pend_toc_nx;
    logic [2:0]         cur_mode, cur_mode_nx, pend_mode, pend_mode_nx;
    logic               timeout_nx, cmd_err_nx;
    logic [NUM_ENG-1:0] eng_en_nx;
    logic [SEL_W-1:0]   mux_sel_nx;
    logic [ADDR_W-1:0]  regf_nx;
    logic               accept, cmd_legal, cur_done, ccc_done, exit_req;
    logic               wd_run, wd_clear, wd_expire;

    function automatic logic [NUM_ENG-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_ENG'(1) << idx;
    endfunction

    // Widened compare so a non-power-of-two engine count is checked exactly.
    function automatic logic is_legal(input logic [SEL_W-1:0] idx);
        return 32'(idx) < 32'(NUM_ENG);
    endfunction

    assign o_cmd_ready = i_hdr_en && ((state == ST_IDLE) || (state == ST_NEXT));
    assign accept      = o_cmd_ready && i_cmd_valid;
    assign cmd_legal   = is_legal(i_cmd_eng);
    // Masking with the one-hot ignores done pulses from other engines.
    assign cur_done    = |(i_eng_done & onehot(cur_eng));
    assign ccc_done    = |(i_eng_done & onehot(CCC_SEL));
    assign exit_req    = cur_toc || (cur_mode != HDR_M);

    assign wd_run   = (state == ST_RUN) || (state == ST_DUMMY);
    assign wd_clear = (state_nx != state);

    hdr_seq_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk    (i_sys_clk),
        .rst    (i_sys_rst),
        .clear  (wd_clear),
        .enable (wd_run),
        .limit  (i_tmo_cycles),
        .expire (wd_expire)
    );

    // Next-state logic plus next values for the registered outputs. The
    // outputs are derived from the next state so that enable and mux select
    // change together on the cycle right after an accept.
    always_comb begin
        state_nx     = state;
        cur_eng_nx   = cur_eng;
        cur_toc_nx   = cur_toc;
        cur_mode_nx  = cur_mode;
        pend_eng_nx  = pend_eng;
        pend_toc_nx  = pend_toc;
        pend_mode_nx = pend_mode;
        timeout_nx   = 1'b0;
        cmd_err_nx   = 1'b0;
        eng_en_nx    = '0;
        mux_sel_nx   = o_mux_sel;
        regf_nx      = IDLE_A;

        if (!i_hdr_en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_eng_nx  = i_cmd_eng;
                        cur_toc_nx  = i_cmd_toc;
                        cur_mode_nx = i_cmd_mode;
                        state_nx    = cmd_legal ? ST_RUN : ST_DONE;
                        cmd_err_nx  = !cmd_legal;
                    end
                end
                ST_RUN: begin
                    // A done in the expiry cycle counts as normal completion.
                    if (cur_done) begin
                        state_nx = exit_req ? ST_DONE : ST_NEXT;
                    end else if (wd_expire) begin
                        state_nx   = ST_DONE;
                        timeout_nx = 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (accept) begin
                        if (!cmd_legal) begin
                            state_nx   = ST_DONE;
                            cmd_err_nx = 1'b1;
                        end else if ((cur_eng == CCC_SEL) && (i_cmd_eng != CCC_SEL)) begin
                            // Leaving CCC: park the new command until the
                            // dummy CCC frame has gone out.
                            pend_eng_nx  = i_cmd_eng;
                            pend_toc_nx  = i_cmd_toc;
                            pend_mode_nx = i_cmd_mode;
                            state_nx     = ST_DUMMY;
                        end else begin
                            cur_eng_nx  = i_cmd_eng;
                            cur_toc_nx  = i_cmd_toc;
                            cur_mode_nx = i_cmd_mode;
                            state_nx    = ST_RUN;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (ccc_done) begin
                        cur_eng_nx  = pend_eng;
                        cur_toc_nx  = pend_toc;
                        cur_mode_nx = pend_mode;
                        state_nx    = ST_RUN;
                    end else if (wd_expire) begin
                        state_nx   = ST_DONE;
                        timeout_nx = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end

        case (state_nx)
            ST_RUN: begin
                eng_en_nx  = onehot(cur_eng_nx);
                mux_sel_nx = cur_eng_nx;
            end
            ST_DUMMY: begin
                eng_en_nx  = onehot(CCC_SEL);
                mux_sel_nx = CCC_SEL;
                regf_nx    = DUMMY_A;
            end
            ST_NEXT: begin
                mux_sel_nx = cur_eng_nx;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state               <= ST_IDLE;
            cur_eng             <= '0;
            cur_toc             <= 1'b0;
            cur_mode            <= '0;
            pend_eng            <= '0;
            pend_toc            <= 1'b0;
            pend_mode           <= '0;
            o_eng_en            <= '0;
            o_mux_sel           <= '0;
            o_regf_addr_special <= IDLE_A;
            o_hdr_done          <= 1'b0;
            o_timeout           <= 1'b0;
            o_cmd_err           <= 1'b0;
        end else begin
            state               <= state_nx;
            cur_eng             <= cur_eng_nx;
            cur_toc             <= cur_toc_nx;
            cur_mode            <= cur_mode_nx;
            pend_eng            <= pend_eng_nx;
            pend_toc            <= pend_toc_nx;
            pend_mode           <= pend_mode_nx;
            o_eng_en            <= eng_en_nx;
            o_mux_sel           <= mux_sel_nx;
            o_regf_addr_special <= regf_nx;
            o_hdr_done          <= (state_nx == ST_DONE);
            o_timeout           <= timeout_nx;
            o_cmd_err           <= cmd_err_nx;
        end
    end

endmodule

// File: tb/tb_hdr_mode_sequencer.sv
// tb_hdr_mode_sequencer
// Directed timing checks followed by randomized command sessions. A
// transaction-level model predicts every engine activation and every HDR
// exit; a monitor compares them as the DUT presents them.
module tb_hdr_mode_sequencer;
    import hdr_seq_pkg::*;

    localparam int NE = 3;
    localparam int SW = 2;
    localparam int AW = 12;

    typedef struct { logic [NE-1:0] en; logic [SW-1:0] sel; logic [AW-1:0] addr; } act_t;
    typedef struct { logic to; logic err; } fin_t;
    typedef struct { logic [SW-1:0] eng; logic toc; logic [2:0] mode; } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hdr_en = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [SW-1:0] cmd_eng = '0;
    logic          cmd_toc = 1'b0;
    logic [2:0]    cmd_mode = '0;
    logic [15:0]   tmo = '0;
    logic [NE-1:0] man_done = '0;
    logic [NE-1:0] resp_done = '0;
    logic [NE-1:0] eng_done;
    logic          auto_resp = 1'b0;
    logic          mon_on = 1'b0;

    logic          cmd_ready;
    logic [NE-1:0] eng_en;
    logic [SW-1:0] mux_sel;
    logic [AW-1:0] regf_addr;
    logic          hdr_done, timeout, cmd_err;

    int n_checks = 0;
    int n_pass = 0;
    int done_seen = 0;

    act_t exp_act_q[$];
    fin_t exp_fin_q[$];
    int   lat_q[$];

    assign eng_done = auto_resp ? resp_done : man_done;

    always #5 clk = ~clk;

    hdr_mode_sequencer #(
        .NUM_ENG (NE)
    ) dut (
        .i_sys_clk           (clk),
        .i_sys_rst           (rst),
        .i_hdr_en            (hdr_en),
        .i_cmd_valid         (cmd_valid),
        .o_cmd_ready         (cmd_ready),
        .i_cmd_eng           (cmd_eng),
        .i_cmd_toc           (cmd_toc),
        .i_cmd_mode          (cmd_mode),
        .i_tmo_cycles        (tmo),
        .i_eng_done          (eng_done),
        .o_eng_en            (eng_en),
        .o_mux_sel           (mux_sel),
        .o_regf_addr_special (regf_addr),
        .o_hdr_done          (hdr_done),
        .o_timeout           (timeout),
        .o_cmd_err           (cmd_err)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("[TB] FAIL %s: event missing or unexpected at %0t", name, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic apply_stimulus(input logic [SW-1:0] eng, input logic toc, input logic [2:0] mode);
        int waited;
        waited    = 0;
        cmd_eng   = eng;
        cmd_toc   = toc;
        cmd_mode  = mode;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept_wait");
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic pulse_done(input logic [NE-1:0] mask);
        man_done = mask;
        @(negedge clk);
        man_done = '0;
    endtask

    // Engine model: each new activation takes its latency from lat_q and
    // raises done on that enable cycle; stray pulses hit idle engines.
    initial begin : responder
        logic [NE-1:0] prev_en;
        int cnt;
        int lat;
        prev_en = '0;
        cnt = 0;
        lat = 0;
        forever begin
            @(negedge clk);
            resp_done = '0;
            if (auto_resp) begin
                if (eng_en != prev_en && eng_en != '0) begin
                    lat = (lat_q.size() > 0) ? lat_q.pop_front() : 100000;
                    cnt = 0;
                end
                if (eng_en != '0) begin
                    cnt++;
                    if (cnt == lat) resp_done = eng_en;
                    else if ($urandom_range(3) == 0) resp_done = ~eng_en & NE'($urandom);
                end
            end
            prev_en = eng_en;
        end
    end

    initial begin : monitor
        logic [NE-1:0] prev_en;
        act_t ea;
        fin_t ef;
        prev_en = '0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (eng_en != prev_en && eng_en != '0) begin
                    if (exp_act_q.size() == 0) fail_now("unexpected_enable");
                    else begin
                        ea = exp_act_q.pop_front();
                        check_output("act_en", eng_en, ea.en);
                        check_output("act_sel", mux_sel, ea.sel);
                        check_output("act_addr", regf_addr, ea.addr);
                    end
                end
                if (hdr_done) begin
                    done_seen++;
                    if (exp_fin_q.size() == 0) fail_now("unexpected_hdr_done");
                    else begin
                        ef = exp_fin_q.pop_front();
                        check_output("fin_timeout", timeout, ef.to);
                        check_output("fin_cmd_err", cmd_err, ef.err);
                    end
                end else if (timeout || cmd_err) begin
                    check_output("stray_pulse", {timeout, cmd_err}, 0);
                end
            end
            prev_en = eng_en;
        end
    end

    initial begin : global_limit
        #400000;
        $display("[TB] FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "[TB] aborted");
    end

    initial begin : main
        cmd_t cmds[$];
        cmd_t c;
        act_t a;
        fin_t f;
        int   lat, cyc, waited, sessions, n;
        logic prev_ccc, ended, seen;

        tick(2);
        check_output("rst_eng_en", eng_en, 0);
        check_output("rst_mux_sel", mux_sel, 0);
        check_output("rst_regf", regf_addr, DEF_IDLE_ADDR);
        check_output("rst_ready", cmd_ready, 0);
        check_output("rst_done", hdr_done, 0);
        check_output("rst_timeout", timeout, 0);
        check_output("rst_err", cmd_err, 0);
        rst = 1'b0;
        hdr_en = 1'b1;
        tick(1);
        check_output("idle_ready", cmd_ready, 1);

        // CCC restart into DDR, with stray done pulses along the way
        apply_stimulus(CCC_ENG_IDX, 1'b0, 3'd6);
        check_output("ccc_en", eng_en, 3'b010);
        check_output("ccc_sel", mux_sel, 1);
        check_output("ccc_ready", cmd_ready, 0);
        pulse_done(3'b001);
        check_output("ccc_ignore_other", eng_en, 3'b010);
        pulse_done(3'b010);
        check_output("next_en", eng_en, 0);
        check_output("next_ready", cmd_ready, 1);
        check_output("next_sel", mux_sel, 1);
        check_output("next_no_done", hdr_done, 0);
        apply_stimulus(DDR_ENG_IDX, 1'b1, 3'd6);
        check_output("dummy_en", eng_en, 3'b010);
        check_output("dummy_sel", mux_sel, 1);
        check_output("dummy_addr", regf_addr, DEF_DUMMY_ADDR);
        pulse_done(3'b001);
        check_output("dummy_ignore_ddr", regf_addr, DEF_DUMMY_ADDR);
        pulse_done(3'b010);
        check_output("ddr_en", eng_en, 3'b001);
        check_output("ddr_sel", mux_sel, 0);
        check_output("ddr_addr", regf_addr, DEF_IDLE_ADDR);
        pulse_done(3'b001);
        check_output("exit_en", eng_en, 0);
        check_output("exit_done", hdr_done, 1);
        check_output("exit_timeout", timeout, 0);
        tick(1);
        check_output("exit_done_once", hdr_done, 0);
        check_output("exit_idle_ready", cmd_ready, 1);

        // Watchdog expiry after 5 RUN cycles
        tmo = 16'd5;
        apply_stimulus(DDR_ENG_IDX, 1'b1, 3'd6);
        cyc = 0;
        while (eng_en != '0 && cyc < 100) begin
            cyc++;
            tick(1);
        end
        check_output("wd_cycles", cyc, 5);
        check_output("wd_done", hdr_done, 1);
        check_output("wd_timeout", timeout, 1);

        // Done in the expiry cycle resolves as normal completion
        tmo = 16'd4;
        apply_stimulus(2'd2, 1'b1, 3'd6);
        tick(3);
        pulse_done(3'b100);
        check_output("tie_en", eng_en, 0);
        check_output("tie_done", hdr_done, 1);
        check_output("tie_timeout", timeout, 0);

        // Watchdog disabled
        tmo = 16'd0;
        apply_stimulus(DDR_ENG_IDX, 1'b1, 3'd6);
        tick(40);
        check_output("wd_off_en", eng_en, 3'b001);
        pulse_done(3'b001);
        check_output("wd_off_done", hdr_done, 1);

        // Non-HDR mode forces exit despite toc=0
        apply_stimulus(DDR_ENG_IDX, 1'b0, 3'd3);
        pulse_done(3'b001);
        check_output("mode_exit_done", hdr_done, 1);
        check_output("mode_exit_ready", cmd_ready, 0);

        // Illegal engine index from IDLE and from NEXT
        apply_stimulus(2'd3, 1'b1, 3'd6);
        check_output("ill_en", eng_en, 0);
        check_output("ill_done", hdr_done, 1);
        check_output("ill_err", cmd_err, 1);
        apply_stimulus(2'd2, 1'b0, 3'd6);
        pulse_done(3'b100);
        check_output("ill_next_ready", cmd_ready, 1);
        apply_stimulus(2'd3, 1'b0, 3'd6);
        check_output("ill_next_done", hdr_done, 1);
        check_output("ill_next_err", cmd_err, 1);

        // DDR restart into CCC: no dummy, CCC enabled two cycles after done
        apply_stimulus(DDR_ENG_IDX, 1'b0, 3'd6);
        pulse_done(3'b001);
        check_output("d2c_ready", cmd_ready, 1);
        apply_stimulus(CCC_ENG_IDX, 1'b1, 3'd6);
        check_output("d2c_en", eng_en, 3'b010);
        check_output("d2c_addr", regf_addr, DEF_IDLE_ADDR);
        pulse_done(3'b010);
        check_output("d2c_done", hdr_done, 1);

        // Enable drop mid-RUN
        apply_stimulus(2'd2, 1'b1, 3'd6);
        hdr_en = 1'b0;
        tick(1);
        check_output("drop_en", eng_en, 0);
        check_output("drop_ready", cmd_ready, 0);
        seen = hdr_done;
        repeat (3) begin
            tick(1);
            seen = seen | hdr_done;
        end
        check_output("drop_no_done", seen, 0);
        hdr_en = 1'b1;
        tick(1);

        // Asynchronous reset while in DUMMY
        apply_stimulus(CCC_ENG_IDX, 1'b0, 3'd6);
        pulse_done(3'b010);
        apply_stimulus(DDR_ENG_IDX, 1'b1, 3'd6);
        check_output("pre_rst_addr", regf_addr, DEF_DUMMY_ADDR);
        #2 rst = 1'b1;
        #1;
        check_output("arst_en", eng_en, 0);
        check_output("arst_sel", mux_sel, 0);
        check_output("arst_addr", regf_addr, DEF_IDLE_ADDR);
        check_output("arst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // Randomized sessions against the transaction-level model
        auto_resp = 1'b1;
        mon_on    = 1'b1;
        sessions  = 0;
        for (int s = 0; s < 40; s++) begin
            tmo = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(10, 3));
            cmds.delete();
            prev_ccc = 1'b0;
            ended = 1'b0;
            n = $urandom_range(4, 1);
            for (int i = 0; i < n && !ended; i++) begin
                c.eng  = ($urandom_range(9) == 0) ? 2'd3 : SW'($urandom_range(2));
                c.mode = ($urandom_range(7) == 0) ? 3'd3 : 3'd6;
                c.toc  = (i == n - 1);
                cmds.push_back(c);
                if (c.eng == 2'd3) begin
                    f.to = 1'b0; f.err = 1'b1;
                    exp_fin_q.push_back(f);
                    ended = 1'b1;
                end else begin
                    if (prev_ccc && c.eng != CCC_ENG_IDX) begin
                        lat = $urandom_range(12, 1);
                        lat_q.push_back(lat);
                        a.en = 3'b010; a.sel = CCC_ENG_IDX; a.addr = DEF_DUMMY_ADDR;
                        exp_act_q.push_back(a);
                        if (tmo != 0 && lat > tmo) begin
                            f.to = 1'b1; f.err = 1'b0;
                            exp_fin_q.push_back(f);
                            ended = 1'b1;
                        end
                    end
                    if (!ended) begin
                        lat = $urandom_range(12, 1);
                        lat_q.push_back(lat);
                        a.en = 3'b001 << c.eng; a.sel = c.eng; a.addr = DEF_IDLE_ADDR;
                        exp_act_q.push_back(a);
                        if (tmo != 0 && lat > tmo) begin
                            f.to = 1'b1; f.err = 1'b0;
                            exp_fin_q.push_back(f);
                            ended = 1'b1;
                        end else if (c.toc || c.mode != 3'd6) begin
                            f.to = 1'b0; f.err = 1'b0;
                            exp_fin_q.push_back(f);
                            ended = 1'b1;
                        end else begin
                            prev_ccc = (c.eng == CCC_ENG_IDX);
                        end
                    end
                end
            end
            sessions++;
            foreach (cmds[i]) apply_stimulus(cmds[i].eng, cmds[i].toc, cmds[i].mode);
            waited = 0;
            while (done_seen < sessions && waited < 300) begin
                tick(1);
                waited++;
            end
            if (done_seen < sessions) fail_now("session_end_wait");
        end
        tick(3);
        check_output("act_q_drained", exp_act_q.size(), 0);
        check_output("fin_q_drained", exp_fin_q.size(), 0);
        check_output("lat_q_drained", lat_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
